// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one full-subtractor cell.
// Optional `SERIAL_SUBTRACTOR_OVF_EN adds a signed-overflow output (ovf).
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             accept, last, handshake;
  logic             d_bit, br_next;

  always_comb begin
    accept    = start_valid && start_ready;
    last      = (state_q == StShift) && (cnt_q == LastCnt);
    handshake = done_valid && done_ready;
    d_bit     = a_q[0] ^ b_q[0] ^ br_q;
    br_next   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept)    state_d = StShift;
      StShift: if (last)      state_d = StDone;
      StDone:  if (handshake) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    start_ready = (state_q == StIdle);
    done_valid  = (state_q == StDone);
  end

  // Operand shifters, borrow flop, result shifter and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      br_q  <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      res_q <= '0;
      br_q  <= bin;
      cnt_q <= '0;
    end else if (state_q == StShift) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      res_q <= {d_bit, res_q[WIDTH-1:1]};
      br_q  <= br_next;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Results load on the final shift edge (DONE entry) so the last bit is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (last) begin
      diff <= {d_bit, res_q[WIDTH-1:1]};
      bout <= br_next;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb_q, b_msb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (accept) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end
  end

  // The final d_bit is the result MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (last) begin
      ovf <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, corner sequences, random ops.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic             clk, rst;
  logic             start_valid, start_ready;
  logic [WIDTH-1:0] a, b;
  logic             bin;
  logic             done_valid, done_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .diff        (diff),
    .bout        (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] exp_diff;
    logic       exp_bout;
    logic       exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: unsigned subtraction in WIDTH+1 bits; the extra bit is the borrow.
  function automatic logic [8:0] ref_sub(input logic [7:0] x, input logic [7:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return 9'(r);
  endfunction

  function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
    int sx, sy, r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = sx - sy - int'(c);
    return (r < -128) || (r > 127);
  endfunction

  task automatic check_result(input string tag, input logic [7:0] ed, input logic eb,
                              input logic eo);
    check({tag, " diff"}, diff, ed);
    check({tag, " bout"}, bout, eb);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check({tag, " ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("unreachable");
`endif
  endtask

  // Accept one operation, measure latency, check result and the follow-up return to IDLE.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        input logic [7:0] ed, input logic eb, input logic eo, input string tag);
    int n;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start_valid = 1'b1; done_ready = 1'b1;
    check({tag, " start_ready idle"}, start_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    check({tag, " start_ready busy"}, start_ready, 1'b0);
    n = 0;
    while (!done_valid && n < 3 * WIDTH) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, WIDTH);
    check_result(tag, ed, eb, eo);
    @(posedge clk);
    @(negedge clk);
    check({tag, " done_valid cleared"}, done_valid, 1'b0);
    check({tag, " start_ready back"}, start_ready, 1'b1);
    check({tag, " diff held"}, diff, ed);
  endtask

  vec_t vecs[7];
  logic [8:0]  r9;
  logic [7:0]  hold_diff;
  logic        hold_bout;
  logic [7:0]  ops_a[3], ops_b[3];
  int          acc_t[3];

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};

    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    check("reset start_ready", start_ready, 1'b1);
    check("reset done_valid", done_valid, 1'b0);
    check("reset diff", diff, 8'h00);
    check("reset bout", bout, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout,
             vecs[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // Backpressure: hold done_ready low, ignored start_valid pulse, then release.
    @(negedge clk);
    a = 8'h9C; b = 8'h21; bin = 1'b0; start_valid = 1'b1; done_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    for (int n = 0; n < 3 * WIDTH && !done_valid; n++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("bp done_valid", done_valid, 1'b1);
    r9 = ref_sub(8'h9C, 8'h21, 1'b0);
    check_result("bp", r9[7:0], r9[8], ref_ovf(8'h9C, 8'h21, 1'b0));
    hold_diff = diff; hold_bout = bout;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin a = 8'h11; b = 8'h22; bin = 1'b1; start_valid = 1'b1; end
      else start_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("bp hold done_valid", done_valid, 1'b1);
      check("bp hold start_ready", start_ready, 1'b0);
      check("bp hold diff", diff, r9[7:0]);
      check("bp hold bout", bout, r9[8]);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release start_ready", start_ready, 1'b1);
    check("bp release done_valid", done_valid, 1'b0);
    r9 = ref_sub(8'h44, 8'h45, 1'b0);
    run_op(8'h44, 8'h45, 1'b0, r9[7:0], r9[8], ref_ovf(8'h44, 8'h45, 1'b0), "bp fresh");

    // Reset during the 4th shift cycle abandons the operation.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; bin = 1'b0; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst mid start_ready", start_ready, 1'b1);
    check("rst mid done_valid", done_valid, 1'b0);
    check("rst mid diff", diff, 8'h00);
    check("rst mid bout", bout, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 2 * WIDTH; k++) begin
        @(negedge clk);
        if (done_valid) seen++;
      end
      check("rst no result", seen, 0);
    end
    run_op(8'h07, 8'h02, 1'b0, 8'h05, 1'b0, 1'b0, "post rst");

    // Back-to-back with start_valid and done_ready held high.
    ops_a[0] = 8'h5A; ops_b[0] = 8'h3C;
    ops_a[1] = 8'h33; ops_b[1] = 8'h44;
    ops_a[2] = 8'hC8; ops_b[2] = 8'h19;
    begin
      int idx, ridx;
      logic pend;
      idx = 0; ridx = 0; pend = 1'b0;
      @(negedge clk);
      a = ops_a[0]; b = ops_b[0]; bin = 1'b0; start_valid = 1'b1; done_ready = 1'b1;
      for (int c = 0; c < 60 && ridx < 3; c++) begin
        if (c > 0) @(negedge clk);
        if (pend) begin
          if (idx < 3) begin a = ops_a[idx]; b = ops_b[idx]; end
          else start_valid = 1'b0;
          pend = 1'b0;
        end
        if (done_valid) begin
          r9 = ref_sub(ops_a[ridx], ops_b[ridx], 1'b0);
          check_result($sformatf("b2b%0d", ridx), r9[7:0], r9[8],
                       ref_ovf(ops_a[ridx], ops_b[ridx], 1'b0));
          ridx++;
        end
        if (start_valid && start_ready && idx < 3) begin
          acc_t[idx] = c;
          idx++;
          pend = 1'b1;
        end
      end
      check("b2b results", ridx, 3);
      check("b2b accepts", idx, 3);
      check("b2b spacing 1", acc_t[1] - acc_t[0], WIDTH + 2);
      check("b2b spacing 2", acc_t[2] - acc_t[1], WIDTH + 2);
      start_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      if (i == 0) begin ra = 8'h00; rb = 8'hFF; rc = 1'b0; end
      if (i == 1) begin ra = 8'hA5; rb = 8'hA5; rc = 1'b0; end
      r9 = ref_sub(ra, rb, rc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(ra, rb, rc, r9[7:0], r9[8], ref_ovf(ra, rb, rc), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
